ram_access_arbiter: RTL and testbench

//  Sequences and shares the single-port 64K SRAM among three requesters:
//  - flash image loader, at boot
//  - CPU bus, from the ramenable decode path
//  - diagnostics SPI slave, while the CPU is halted

---
 rtl/ram_access_arbiter_pkg.sv | 22 ++
 rtl/ram_access_arbiter_if.sv | 61 ++++++
 rtl/ram_arb_mux.sv | 57 +++++
 rtl/ram_access_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_access_arbiter_pkg.sv
// Shared types for the SRAM access arbiter: phase states and requester codes.
package ram_access_arbiter_pkg;

  // Phase FSM encoding.
  typedef enum logic [1:0] {
    ST_LOAD      = 2'd0,
    ST_RUN       = 2'd1,
    ST_HALT_WAIT = 2'd2,
    ST_HALTED    = 2'd3
  } state_e;

  // Requester codes, also reported on rd_owner.
  typedef enum logic [1:0] {
    OWN_FLASH = 2'd0,
    OWN_CPU   = 2'd1,
    OWN_DIAG  = 2'd2
  } owner_e;

  // Width of the halt settle counter.
  localparam int SETTLE_W = 4;

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Bus bundle between the three requesters, the arbiter and the SRAM.
// slave = arbiter side, master = requester/SRAM side.
interface ram_access_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              load_done;
  logic              halt_req;
  logic              halted;
  logic              rdy;

  logic              flash_req;
  logic              flash_we;
  logic [ADDR_W-1:0] flash_addr;
  logic [DATA_W-1:0] flash_wdata;
  logic              flash_ack;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;

  logic              diag_req;
  logic              diag_we;
  logic [ADDR_W-1:0] diag_addr;
  logic [DATA_W-1:0] diag_wdata;
  logic              diag_ack;

  logic              rd_valid;
  logic [1:0]        rd_owner;
  logic [DATA_W-1:0] rd_data;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_cs;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  load_done, halt_req,
    input  flash_req, flash_we, flash_addr, flash_wdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  diag_req, diag_we, diag_addr, diag_wdata,
    input  ram_rdata,
    output halted, rdy, flash_ack, cpu_ack, diag_ack,
    output rd_valid, rd_owner, rd_data,
    output ram_addr, ram_wdata, ram_cs, ram_we
  );

  modport master (
    output load_done, halt_req,
    output flash_req, flash_we, flash_addr, flash_wdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output diag_req, diag_we, diag_addr, diag_wdata,
    output ram_rdata,
    input  halted, rdy, flash_ack, cpu_ack, diag_ack,
    input  rd_valid, rd_owner, rd_data,
    input  ram_addr, ram_wdata, ram_cs, ram_we
  );
endinterface

// File: rtl/ram_arb_mux.sv
// SRAM command mux: steers the granted requester's address, data and
// write enable onto the SRAM. Drives zeros when nothing is selected.
module ram_arb_mux
  import ram_access_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  owner_e            owner,
  input  logic              cs,
  input  logic              flash_we,
  input  logic [ADDR_W-1:0] flash_addr,
  input  logic [DATA_W-1:0] flash_wdata,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              diag_we,
  input  logic [ADDR_W-1:0] diag_addr,
  input  logic [DATA_W-1:0] diag_wdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we
);

  // Select the owner's command fields when an access is issued.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (cs) begin
      case (owner)
        OWN_FLASH: begin
          ram_addr  = flash_addr;
          ram_wdata = flash_wdata;
          ram_we    = flash_we;
        end
        OWN_CPU: begin
          ram_addr  = cpu_addr;
          ram_wdata = cpu_wdata;
          ram_we    = cpu_we;
        end
        OWN_DIAG: begin
          ram_addr  = diag_addr;
          ram_wdata = diag_wdata;
          ram_we    = diag_we;
        end
        default: begin
          ram_addr  = '0;
          ram_wdata = '0;
          ram_we    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares the single-port SRAM between the flash loader (boot), the CPU (run)
// and the diagnostics port (while the CPU is halted). A phase FSM decides
// which single requester may be granted; the halt settle counter delays
// handing the RAM to diagnostics until the CPU has been idle long enough.
module ram_access_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int HALT_SETTLE = 4
) (
  input logic                  clk,
  input logic                  rst,
  ram_access_arbiter_if.slave  bus
);
  import ram_access_arbiter_pkg::*;

  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(HALT_SETTLE);

  state_e              state;
  logic                loaded;
  logic                halted_q;
  logic [SETTLE_W-1:0] settle_cnt;

  logic                flash_ack;
  logic                cpu_ack;
  logic                diag_ack;
  logic                any_ack;
  owner_e              owner;

  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic                ram_we;
  logic                read_issue;

  logic                rd_valid_q;
  owner_e              rd_owner_q;
  logic [DATA_W-1:0]   rd_hold;

  // Grant: only the phase's owner can be acked, so at most one ack per cycle.
  // Nothing is granted while reset is asserted.
  always_comb begin
    flash_ack = 1'b0;
    cpu_ack   = 1'b0;
    diag_ack  = 1'b0;
    if (!rst) begin
      case (state)
        ST_LOAD:                flash_ack = bus.flash_req;
        ST_RUN, ST_HALT_WAIT:   cpu_ack   = bus.cpu_req;
        ST_HALTED:              diag_ack  = bus.diag_req;
        default: ;
      endcase
    end
  end

  // Owner code of the access issued this cycle.
  always_comb begin
    owner = OWN_FLASH;
    if (cpu_ack)       owner = OWN_CPU;
    else if (diag_ack) owner = OWN_DIAG;
  end

  assign any_ack    = flash_ack | cpu_ack | diag_ack;
  assign read_issue = any_ack & ~ram_we;

  ram_arb_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .owner       (owner),
    .cs          (any_ack),
    .flash_we    (bus.flash_we),
    .flash_addr  (bus.flash_addr),
    .flash_wdata (bus.flash_wdata),
    .cpu_we      (bus.cpu_we),
    .cpu_addr    (bus.cpu_addr),
    .cpu_wdata   (bus.cpu_wdata),
    .diag_we     (bus.diag_we),
    .diag_addr   (bus.diag_addr),
    .diag_wdata  (bus.diag_wdata),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we)
  );

  // Phase FSM with the halt settle counter and the registered halted flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= ST_LOAD;
      loaded     <= 1'b0;
      halted_q   <= 1'b0;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          // load_done is only looked at here, which makes it sticky.
          if (bus.load_done) begin
            loaded <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.halt_req) begin
            settle_cnt <= SETTLE_INIT;
            state      <= ST_HALT_WAIT;
          end
        end
        ST_HALT_WAIT: begin
          if (!bus.halt_req) begin
            settle_cnt <= '0;
            state      <= ST_RUN;
          end else if (cpu_ack) begin
            settle_cnt <= SETTLE_INIT;
          end else if (settle_cnt <= SETTLE_W'(1)) begin
            // Last idle cycle of the settle window: hand the RAM to diagnostics.
            settle_cnt <= '0;
            halted_q   <= 1'b1;
            state      <= ST_HALTED;
          end else begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
          end
        end
        ST_HALTED: begin
          if (!bus.halt_req) begin
            halted_q <= 1'b0;
            state    <= ST_RUN;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Read return tracking: flag and owner one cycle after a read issue;
  // the data word is held once the SRAM has presented it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= OWN_FLASH;
      rd_hold    <= '0;
    end else begin
      rd_valid_q <= read_issue;
      if (read_issue) rd_owner_q <= owner;
      if (rd_valid_q) rd_hold    <= bus.ram_rdata;
    end
  end

  // The SRAM presents read data in the cycle after issue, which is the
  // rd_valid cycle, so rd_data shows it directly then and the held copy after.
  assign bus.rd_data   = rd_valid_q ? bus.ram_rdata : rd_hold;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_owner  = rd_owner_q;

  assign bus.flash_ack = flash_ack;
  assign bus.cpu_ack   = cpu_ack;
  assign bus.diag_ack  = diag_ack;

  assign bus.ram_cs    = any_ack;
  assign bus.ram_we    = ram_we;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_wdata = ram_wdata;

  assign bus.halted    = halted_q;
  assign bus.rdy       = !rst && !halted_q && loaded && !bus.halt_req;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: boot, CPU access, halt settle,
// diagnostics access, abort/unhalt and mid-access reset.
module tb_ram_access_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  ram_access_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  ram_access_arbiter #(.ADDR_W(16), .DATA_W(8), .HALT_SETTLE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Synchronous single-port SRAM: read data appears the cycle after issue.
  logic [7:0] mem [0:65535];
  logic [7:0] sram_q = 8'h00;
  always @(posedge clk) begin
    if (bus.ram_cs) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            sram_q <= mem[bus.ram_addr];
    end
  end
  assign bus.ram_rdata = sram_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flash(input logic req, input logic we, input logic [15:0] addr, input logic [7:0] wd);
    bus.flash_req = req; bus.flash_we = we; bus.flash_addr = addr; bus.flash_wdata = wd;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [15:0] addr, input logic [7:0] wd);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
  endtask

  task automatic set_diag(input logic req, input logic we, input logic [15:0] addr, input logic [7:0] wd);
    bus.diag_req = req; bus.diag_we = we; bus.diag_addr = addr; bus.diag_wdata = wd;
  endtask

  task automatic test_reset();
    step(); step();
    set_flash(1'b1, 1'b0, 16'h0005, 8'h00);
    #1;
    total++; if (bus.flash_ack !== 1'b0) begin bad++; $display("FAIL rst_flash_ack: got %b want 0", bus.flash_ack); end
    total++; if (bus.ram_cs !== 1'b0) begin bad++; $display("FAIL rst_ram_cs: got %b want 0", bus.ram_cs); end
    total++; if (bus.ram_addr !== 16'h0000) begin bad++; $display("FAIL rst_ram_addr: got %h want 0000", bus.ram_addr); end
    total++; if (bus.halted !== 1'b0 || bus.rdy !== 1'b0) begin bad++; $display("FAIL rst_halted_rdy: got %b%b want 00", bus.halted, bus.rdy); end
    total++; if (bus.rd_valid !== 1'b0 || bus.rd_owner !== 2'd0 || bus.rd_data !== 8'h00) begin bad++; $display("FAIL rst_rd: got v=%b o=%0d d=%h want v=0 o=0 d=00", bus.rd_valid, bus.rd_owner, bus.rd_data); end
  endtask

  task automatic test_boot();
    step();
    rst = 1'b0;
    set_flash(1'b1, 1'b1, 16'h0000, 8'hA5);
    set_cpu(1'b1, 1'b0, 16'h0000, 8'h00);
    #1;
    total++; if (bus.flash_ack !== 1'b1 || bus.cpu_ack !== 1'b0) begin bad++; $display("FAIL boot_wr0_acks: got f=%b c=%b want f=1 c=0", bus.flash_ack, bus.cpu_ack); end
    total++; if (bus.ram_cs !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 16'h0000 || bus.ram_wdata !== 8'hA5) begin bad++; $display("FAIL boot_wr0_cmd: got cs=%b we=%b a=%h d=%h want 1 1 0000 a5", bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wdata); end
    total++; if (bus.rdy !== 1'b0) begin bad++; $display("FAIL boot_rdy_load: got %b want 0", bus.rdy); end
    step();
    set_flash(1'b1, 1'b1, 16'hFFFF, 8'h3C);
    #1;
    total++; if (bus.flash_ack !== 1'b1 || bus.cpu_ack !== 1'b0) begin bad++; $display("FAIL boot_wr1_acks: got f=%b c=%b want f=1 c=0", bus.flash_ack, bus.cpu_ack); end
    total++; if (bus.ram_addr !== 16'hFFFF || bus.ram_wdata !== 8'h3C) begin bad++; $display("FAIL boot_wr1_cmd: got a=%h d=%h want ffff 3c", bus.ram_addr, bus.ram_wdata); end
    step();
    set_flash(1'b0, 1'b0, 16'h0000, 8'h00);
    bus.load_done = 1'b1;
    #1;
    total++; if (bus.cpu_ack !== 1'b0 || bus.rdy !== 1'b0) begin bad++; $display("FAIL boot_done_cycle: got c=%b rdy=%b want 0 0", bus.cpu_ack, bus.rdy); end
    step();
    bus.load_done = 1'b0;
    set_flash(1'b1, 1'b0, 16'h0000, 8'h00);
    #1;
    total++; if (bus.cpu_ack !== 1'b1 || bus.flash_ack !== 1'b0) begin bad++; $display("FAIL boot_run_acks: got c=%b f=%b want c=1 f=0", bus.cpu_ack, bus.flash_ack); end
    total++; if (bus.rdy !== 1'b1 || bus.ram_we !== 1'b0) begin bad++; $display("FAIL boot_run_rdy: got rdy=%b we=%b want 1 0", bus.rdy, bus.ram_we); end
    step();
    set_flash(1'b0, 1'b0, 16'h0000, 8'h00);
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_owner !== 2'd1 || bus.rd_data !== 8'hA5) begin bad++; $display("FAIL boot_cpu_rd: got v=%b o=%0d d=%h want 1 1 a5", bus.rd_valid, bus.rd_owner, bus.rd_data); end
  endtask

  task automatic test_cpu_read();
    step();
    set_cpu(1'b1, 1'b0, 16'hFFFF, 8'h00);
    #1;
    total++; if (bus.cpu_ack !== 1'b1 || bus.ram_addr !== 16'hFFFF) begin bad++; $display("FAIL cpu_rd_issue: got ack=%b a=%h want 1 ffff", bus.cpu_ack, bus.ram_addr); end
    step();
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_owner !== 2'd1 || bus.rd_data !== 8'h3C) begin bad++; $display("FAIL cpu_rd_return: got v=%b o=%0d d=%h want 1 1 3c", bus.rd_valid, bus.rd_owner, bus.rd_data); end
    step();
    #1;
    total++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h3C) begin bad++; $display("FAIL cpu_rd_after: got v=%b d=%h want 0 3c", bus.rd_valid, bus.rd_data); end
  endtask

  task automatic test_back_to_back();
    step();
    set_cpu(1'b1, 1'b1, 16'h0010, 8'h5A);
    #1;
    total++; if (bus.cpu_ack !== 1'b1 || bus.ram_we !== 1'b1) begin bad++; $display("FAIL b2b_wr: got ack=%b we=%b want 1 1", bus.cpu_ack, bus.ram_we); end
    step();
    set_cpu(1'b1, 1'b0, 16'h0010, 8'h00);
    #1;
    total++; if (bus.cpu_ack !== 1'b1 || bus.rd_valid !== 1'b0) begin bad++; $display("FAIL b2b_rd1: got ack=%b v=%b want 1 0", bus.cpu_ack, bus.rd_valid); end
    step();
    set_cpu(1'b1, 1'b0, 16'h0000, 8'h00);
    #1;
    total++; if (bus.cpu_ack !== 1'b1 || bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h5A) begin bad++; $display("FAIL b2b_rd2: got ack=%b v=%b d=%h want 1 1 5a", bus.cpu_ack, bus.rd_valid, bus.rd_data); end
    step();
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hA5) begin bad++; $display("FAIL b2b_rd3: got v=%b d=%h want 1 a5", bus.rd_valid, bus.rd_data); end
  endtask

  task automatic test_halt_settle();
    step();
    bus.halt_req = 1'b1;
    set_cpu(1'b1, 1'b0, 16'h0010, 8'h00);
    set_diag(1'b1, 1'b1, 16'h1234, 8'h77);
    #1;
    total++; if (bus.rdy !== 1'b0 || bus.cpu_ack !== 1'b1 || bus.diag_ack !== 1'b0) begin bad++; $display("FAIL halt_enter: got rdy=%b c=%b d=%b want 0 1 0", bus.rdy, bus.cpu_ack, bus.diag_ack); end
    step();
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    total++; if (bus.halted !== 1'b0 || bus.diag_ack !== 1'b0 || bus.rdy !== 1'b0) begin bad++; $display("FAIL halt_gap: got h=%b d=%b rdy=%b want 0 0 0", bus.halted, bus.diag_ack, bus.rdy); end
    step();
    set_cpu(1'b1, 1'b0, 16'h0000, 8'h00);
    #1;
    total++; if (bus.cpu_ack !== 1'b1 || bus.diag_ack !== 1'b0) begin bad++; $display("FAIL halt_wait_cpu: got c=%b d=%b want 1 0", bus.cpu_ack, bus.diag_ack); end
    step();
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) step();
      #1;
      total++; if (bus.halted !== 1'b0 || bus.diag_ack !== 1'b0) begin bad++; $display("FAIL halt_settle_%0d: got h=%b d=%b want 0 0", i, bus.halted, bus.diag_ack); end
    end
    step();
    set_cpu(1'b1, 1'b0, 16'h0020, 8'h00);
    #1;
    total++; if (bus.halted !== 1'b1 || bus.rdy !== 1'b0) begin bad++; $display("FAIL halt_reached: got h=%b rdy=%b want 1 0", bus.halted, bus.rdy); end
  endtask

  task automatic test_diag();
    total++; if (bus.diag_ack !== 1'b1 || bus.cpu_ack !== 1'b0) begin bad++; $display("FAIL diag_wr_acks: got d=%b c=%b want 1 0", bus.diag_ack, bus.cpu_ack); end
    total++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 16'h1234 || bus.ram_wdata !== 8'h77) begin bad++; $display("FAIL diag_wr_cmd: got we=%b a=%h d=%h want 1 1234 77", bus.ram_we, bus.ram_addr, bus.ram_wdata); end
    step();
    set_diag(1'b1, 1'b0, 16'h1234, 8'h00);
    #1;
    total++; if (bus.diag_ack !== 1'b1 || bus.cpu_ack !== 1'b0 || bus.ram_we !== 1'b0) begin bad++; $display("FAIL diag_rd_issue: got d=%b c=%b we=%b want 1 0 0", bus.diag_ack, bus.cpu_ack, bus.ram_we); end
    step();
    set_diag(1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_owner !== 2'd2 || bus.rd_data !== 8'h77) begin bad++; $display("FAIL diag_rd_return: got v=%b o=%0d d=%h want 1 2 77", bus.rd_valid, bus.rd_owner, bus.rd_data); end
    total++; if (bus.halted !== 1'b1 || bus.cpu_ack !== 1'b0) begin bad++; $display("FAIL diag_cpu_stall: got h=%b c=%b want 1 0", bus.halted, bus.cpu_ack); end
  endtask

  task automatic test_unhalt();
    step();
    bus.halt_req = 1'b0;
    set_diag(1'b1, 1'b0, 16'hFFFF, 8'h00);
    #1;
    total++; if (bus.diag_ack !== 1'b1 || bus.halted !== 1'b1) begin bad++; $display("FAIL unhalt_last_diag: got d=%b h=%b want 1 1", bus.diag_ack, bus.halted); end
    step();
    set_diag(1'b0, 1'b0, 16'h0000, 8'h00);
    set_cpu(1'b1, 1'b0, 16'h0010, 8'h00);
    #1;
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_owner !== 2'd2 || bus.rd_data !== 8'h3C) begin bad++; $display("FAIL unhalt_rd_return: got v=%b o=%0d d=%h want 1 2 3c", bus.rd_valid, bus.rd_owner, bus.rd_data); end
    total++; if (bus.halted !== 1'b0 || bus.rdy !== 1'b1 || bus.cpu_ack !== 1'b1) begin bad++; $display("FAIL unhalt_run: got h=%b rdy=%b c=%b want 0 1 1", bus.halted, bus.rdy, bus.cpu_ack); end
  endtask

  task automatic test_abort();
    step();
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    bus.halt_req = 1'b1;
    #1;
    total++; if (bus.rdy !== 1'b0) begin bad++; $display("FAIL abort_rdy_drop: got %b want 0", bus.rdy); end
    step();
    #1;
    total++; if (bus.halted !== 1'b0 || bus.rdy !== 1'b0) begin bad++; $display("FAIL abort_wait: got h=%b rdy=%b want 0 0", bus.halted, bus.rdy); end
    step();
    bus.halt_req = 1'b0;
    #1;
    total++; if (bus.rdy !== 1'b1 || bus.halted !== 1'b0) begin bad++; $display("FAIL abort_release: got rdy=%b h=%b want 1 0", bus.rdy, bus.halted); end
    step();
    set_cpu(1'b1, 1'b0, 16'hFFFF, 8'h00);
    #1;
    total++; if (bus.cpu_ack !== 1'b1 || bus.halted !== 1'b0) begin bad++; $display("FAIL abort_run_cpu: got c=%b h=%b want 1 0", bus.cpu_ack, bus.halted); end
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step();
      #1;
      total++; if (bus.halted !== 1'b0 || bus.rdy !== 1'b1) begin bad++; $display("FAIL abort_no_halt_%0d: got h=%b rdy=%b want 0 1", i, bus.halted, bus.rdy); end
    end
  endtask

  task automatic test_reset_mid();
    step();
    set_cpu(1'b1, 1'b0, 16'hFFFF, 8'h00);
    rst = 1'b1;
    #1;
    total++; if (bus.cpu_ack !== 1'b0 || bus.ram_cs !== 1'b0) begin bad++; $display("FAIL rstmid_drop: got c=%b cs=%b want 0 0", bus.cpu_ack, bus.ram_cs); end
    step();
    rst = 1'b0;
    set_flash(1'b1, 1'b0, 16'h0000, 8'h00);
    #1;
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_rd: got %b want 0", bus.rd_valid); end
    total++; if (bus.flash_ack !== 1'b1 || bus.cpu_ack !== 1'b0 || bus.rdy !== 1'b0) begin bad++; $display("FAIL rstmid_load: got f=%b c=%b rdy=%b want 1 0 0", bus.flash_ack, bus.cpu_ack, bus.rdy); end
    step();
    set_flash(1'b0, 1'b0, 16'h0000, 8'h00);
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_owner !== 2'd0 || bus.rd_data !== 8'hA5) begin bad++; $display("FAIL rstmid_flash_rd: got v=%b o=%0d d=%h want 1 0 a5", bus.rd_valid, bus.rd_owner, bus.rd_data); end
  endtask

  initial begin
    bus.load_done = 1'b0;
    bus.halt_req  = 1'b0;
    set_flash(1'b0, 1'b0, 16'h0000, 8'h00);
    set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    set_diag(1'b0, 1'b0, 16'h0000, 8'h00);
    test_reset();
    test_boot();
    test_cpu_read();
    test_back_to_back();
    test_halt_settle();
    test_diag();
    test_unhalt();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
